// File: rtl/sysid_regs_pkg.sv
// Shared constants for the sysid_regs register file: address map, register count
// and the layout of the capabilities word.
package sysid_regs_pkg;

    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    localparam logic [ADDR_W-1:0] ADDR_SYSID   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_TSTAMP  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_VERSION = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_SCRATCH = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_UPLO    = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_UPHI    = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_CAPS    = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_CLKDIV  = 3'd7;

    localparam int CAPS_LAT_LSB   = 0;
    localparam int CAPS_NREGS_LSB = 8;
    localparam int CAPS_FIELD_W   = 8;

    function automatic logic [31:0] caps_word(input int unsigned lat);
        logic [31:0] w;
        w = '0;
        w[CAPS_NREGS_LSB +: CAPS_FIELD_W] = CAPS_FIELD_W'(NUM_REGS);
        w[CAPS_LAT_LSB +: CAPS_FIELD_W]   = CAPS_FIELD_W'(lat);
        return w;
    endfunction

endpackage

// File: rtl/sysid_regs_if.sv
// Avalon-MM slave bundle for sysid_regs (no waitrequest, pipelined read data).
interface sysid_regs_if;
    import sysid_regs_pkg::*;

    logic              chipselect;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output chipselect, address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  chipselect, address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );

endinterface

// File: rtl/sysid_regs_uptime.sv
// Free-running 64-bit uptime counter advanced once every CLK_DIV clocks.
module sysid_uptime #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] uptime
);

    localparam int unsigned     PW       = 17;
    localparam logic [PW-1:0]   DIV_LAST = PW'(CLK_DIV - 1);

    if (CLK_DIV == 0 || CLK_DIV > 65536) begin : g_bad_div
        $error("sysid_uptime: CLK_DIV must be in 1..65536");
    end

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc  <= '0;
            uptime <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                uptime <= uptime + 64'd1;
            end
        end
    end

endmodule

// File: rtl/sysid_regs.sv
// System-ID register file: identity words, scratch, uptime with coherent hi/lo
// snapshot, and a read-data pipeline of READ_LATENCY registers.
module sysid_regs
    import sysid_regs_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
    parameter logic [31:0] VERSION       = 32'h0001_0000,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned CLK_DIV       = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    sysid_regs_if.slave  bus
);

    if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_lat
        $error("sysid_regs: READ_LATENCY must be in 1..3");
    end

    localparam logic [31:0] CAPS_VAL   = caps_word(READ_LATENCY);
    localparam logic [31:0] CLKDIV_VAL = 32'(CLK_DIV);

    function automatic logic [31:0] be_merge(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    logic [63:0] uptime;
    logic [31:0] scratch;
    logic [31:0] hi_shadow;
    logic [31:0] rd_sel;
    logic        rd_acc;
    logic        wr_acc;

    logic [31:0] rdata_p0, rdata_p1, rdata_p2;
    logic        vld_p0, vld_p1, vld_p2;

    sysid_uptime #(
        .CLK_DIV (CLK_DIV)
    ) u_uptime (
        .clk     (clk),
        .reset_n (reset_n),
        .uptime  (uptime)
    );

    // A simultaneous read and write is treated as a write only.
    assign wr_acc = bus.chipselect & bus.write;
    assign rd_acc = bus.chipselect & bus.read & ~bus.write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scratch <= SCRATCH_RESET;
        end else if (wr_acc && bus.address == ADDR_SCRATCH) begin
            scratch <= be_merge(scratch, bus.writedata, bus.byteenable);
        end
    end

    // The hi half is captured by the same edge that returns the lo half, so a
    // LO-then-HI pair never straddles a carry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_shadow <= '0;
        end else if (rd_acc && bus.address == ADDR_UPLO) begin
            hi_shadow <= uptime[63:32];
        end
    end

    always_comb begin
        rd_sel = '0;
        case (bus.address)
            ADDR_SYSID:   rd_sel = SYSTEM_ID;
            ADDR_TSTAMP:  rd_sel = TIMESTAMP;
            ADDR_VERSION: rd_sel = VERSION;
            ADDR_SCRATCH: rd_sel = scratch;
            ADDR_UPLO:    rd_sel = uptime[31:0];
            ADDR_UPHI:    rd_sel = hi_shadow;
            ADDR_CAPS:    rd_sel = CAPS_VAL;
            ADDR_CLKDIV:  rd_sel = CLKDIV_VAL;
            default:      rd_sel = '0;
        endcase
    end

    // Stage p0: selected data registered in the accept cycle.
    // Stages p1/p2: extra latency; data moves only with its valid so the
    // output holds between responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= rd_acc;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_p0 <= '0;
            rdata_p1 <= '0;
            rdata_p2 <= '0;
        end else begin
            if (rd_acc) rdata_p0 <= rd_sel;
            if (vld_p0) rdata_p1 <= rdata_p0;
            if (vld_p1) rdata_p2 <= rdata_p1;
        end
    end

    always_comb begin
        bus.readdata      = rdata_p0;
        bus.readdatavalid = vld_p0;
        if (READ_LATENCY == 2) begin
            bus.readdata      = rdata_p1;
            bus.readdatavalid = vld_p1;
        end else if (READ_LATENCY == 3) begin
            bus.readdata      = rdata_p2;
            bus.readdatavalid = vld_p2;
        end
    end

endmodule

// File: doc/sysid_regs.md
Name: sysid_regs

Overview:
- Parametrised successor to the fixed single-word system-ID slave. Provides a small Avalon-MM register file:
  - system ID and build timestamp words;
  - version word;
  - read/write scratch register;
  - 64-bit free-running uptime counter with coherent hi/lo snapshot;
  - capability words.
- Sits on the Nios II data master's interconnect. Software uses it to confirm that hardware and software match, and to read a coarse time base.
- Read data is registered, with configurable pipeline latency.

Parameters:
- SYSTEM_ID, 32'h0000_0000, value returned at address 0
- TIMESTAMP, 32'h0000_0000, build timestamp returned at address 1
- VERSION, 32'h0001_0000, {major[31:16], minor[15:0]} returned at address 2
- SCRATCH_RESET, 32'h0000_0000, reset value of scratch register
- READ_LATENCY, 1, cycles from read accept to readdatavalid; legal 1..3
- CLK_DIV, 1, clocks per uptime increment; legal 1..2^16

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- chipselect  input  1  slave select
- address  input  3  word address
- read  input  1  read strobe
- write  input  1  write strobe
- writedata  input  32  write data
- byteenable  input  4  byte lanes for write
- readdata  output  32  registered read data
- readdatavalid  output  1  readdata qualifier, one cycle per accepted read

Behaviour:
- Reset is asynchronous, active-low, and fixed as decided:
  - readdata = 0, readdatavalid = 0, pipeline valid bits = 0;
  - scratch = SCRATCH_RESET;
  - uptime = 0, prescaler = 0, hi-shadow = 0.
- Reset asserted mid-read drops all in-flight reads. No readdatavalid is produced for them.
- Accepting requests (no waitrequest; one request per cycle, every cycle):
  - read accepted when chipselect & read & !write;
  - write accepted when chipselect & write. If read and write are both asserted, the write is performed and the read is ignored.
- Address map:
  - 0 SYSTEM_ID (RO)
  - 1 TIMESTAMP (RO)
  - 2 VERSION (RO)
  - 3 SCRATCH (RW)
  - 4 UPTIME_LO (RO)
  - 5 UPTIME_HI (RO, returns shadow)
  - 6 CAPS = {16'h0, 8'd8 (register count), 8'(READ_LATENCY)}
  - 7 CLK_DIV (32-bit, zero-extended)
- Writes:
  - Writes to any address other than 3 are ignored.
  - SCRATCH byte lane i updates only if byteenable[i].
  - A write is visible to a read accepted on the following cycle.
- Read pipeline:
  - Data is selected and registered in the accept cycle.
  - It then passes through READ_LATENCY-1 further registers.
  - readdatavalid is asserted exactly READ_LATENCY cycles after the accept edge.
  - Back-to-back reads produce back-to-back valids, in order.
  - readdata holds its last value while readdatavalid = 0.
- Uptime:
  - Prescaler counts 0..CLK_DIV-1 and wraps. A tick is generated on the wrap (every cycle when CLK_DIV = 1).
  - The 64-bit uptime increments on each tick and wraps from 2^64-1 to 0.
- Snapshot:
  - A read accepted at address 4 returns the uptime[31:0] sampled in the accept cycle.
  - The same edge loads the hi-shadow with uptime[63:32] as sampled in that cycle, i.e. the same value before any increment.
  - Address 5 returns the hi-shadow and never reads the live counter, so a LO-then-HI pair is always coherent across a carry.
  - Address 5 read before any LO read returns 0.
- Parameter check: READ_LATENCY outside 1..3 or CLK_DIV = 0 causes an elaboration-time error.

Decomposition:
- Package sysid_regs_pkg:
  - address constants ADDR_SYSID..ADDR_CLKDIV (3-bit);
  - NUM_REGS = 8;
  - CAPS field positions.
- Sub-module sysid_uptime (params CLK_DIV):
  - contains the prescaler and 64-bit counter;
  - ports clk, reset_n, uptime[63:0].
- Top level holds the decode, scratch register, shadow and read pipeline.

Test Plan:
- Reset, then with SYSTEM_ID=32'hCAFE0001, TIMESTAMP=32'h5CA10000, READ_LATENCY=2, read addresses 0, 1, 2, 6 back-to-back:
  - readdatavalid high on 4 consecutive cycles, starting 2 cycles after the first accept;
  - data 32'hCAFE0001, 32'h5CA10000, 32'h00010000, 32'h00000802.
- Write 32'h12345678 with be=4'hF to address 3, then 32'hAABBCCDD with be=4'b0101:
  - next read of address 3 returns 32'h12BB56DD;
  - a write of 32'hFFFFFFFF to address 0 leaves the address-0 read unchanged.
- CLK_DIV=4:
  - force uptime to 64'h0000_0000_FFFF_FFFF just before a tick;
  - read LO in the tick cycle, then HI: expect LO=32'hFFFFFFFF, HI=0;
  - a fresh LO read returns 0 and the following HI read returns 1.
- CLK_DIV=1, reset released at t0:
  - an address-4 read accepted N cycles later returns N (±0 per the defined reset-release edge).
- Read and write asserted together at address 3 with writedata 32'h1:
  - no readdatavalid is produced;
  - scratch becomes 1.
- reset_n asserted while 2 reads are in flight (READ_LATENCY=3):
  - readdatavalid stays 0 and readdata=0;
  - scratch returns to SCRATCH_RESET.
